// File: rtl/fpadder_driver.sv
// rtl/fpadder_driver.sv - sequencer feeding operand pairs to a free-running fpadder
// Drives A then B after each adder ready pulse and queues real sums in an in-order FIFO.
module fpadder_driver #(
  parameter int RES_DEPTH = 2,
  parameter int TIMEOUT   = 512
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_sum,
  output logic [31:0] fp_a,
  input  logic        fp_ready,
  input  logic [31:0] fp_sum,
  output logic        busy,
  output logic        timeout_err
);

  localparam int PW  = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
  localparam int CW  = $clog2(RES_DEPTH + 1);
  localparam int CW1 = CW + 1;
  localparam int TW  = $clog2(TIMEOUT + 1);

  localparam logic [PW-1:0] LAST_PTR = PW'(RES_DEPTH - 1);
  localparam logic [CW:0]   DEPTH_C  = CW1'(RES_DEPTH);
  localparam logic [TW-1:0] TMAX     = TW'(TIMEOUT);

  typedef enum logic [1:0] {
    WAIT_RDY,
    SEND_A,
    SEND_B
  } state_t;

  state_t        state;
  logic          inflight_real;
  logic [31:0]   b_lat;
  logic [TW-1:0] tcnt;

  logic [31:0]   mem [RES_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] fifo_cnt;
  logic [CW:0]   credit_used;

  logic slot;
  logic push;
  logic pop;
  logic accept;

  // A pop in the same cycle is deliberately not credited back to op_ready.
  assign slot        = (state == WAIT_RDY) && fp_ready;
  assign push        = slot && inflight_real;
  assign credit_used = {1'b0, fifo_cnt} + {{CW{1'b0}}, inflight_real};
  assign op_ready    = slot && (credit_used < DEPTH_C);
  assign accept      = op_valid && op_ready;
  assign res_valid   = (fifo_cnt != '0);
  assign pop         = res_valid && res_ready;
  assign res_sum     = res_valid ? mem[rd_ptr] : '0;
  assign busy        = inflight_real || res_valid;

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= WAIT_RDY;
      inflight_real <= 1'b0;
      b_lat         <= '0;
      fp_a          <= '0;
      tcnt          <= '0;
      timeout_err   <= 1'b0;
    end else begin
      case (state)
        WAIT_RDY: begin
          if (fp_ready) begin
            state         <= SEND_A;
            inflight_real <= accept;
            fp_a          <= accept ? op_a : '0;
            if (accept) b_lat <= op_b;
          end else if (tcnt != TMAX) begin
            tcnt <= tcnt + 1'b1;
            if (tcnt == TMAX - 1'b1) timeout_err <= 1'b1;
          end
        end
        SEND_A: begin
          state <= SEND_B;
          fp_a  <= inflight_real ? b_lat : '0;
        end
        SEND_B: begin
          state <= WAIT_RDY;
          fp_a  <= '0;
          tcnt  <= '0;
        end
        default: begin
          state <= WAIT_RDY;
          fp_a  <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (pop && !push) fifo_cnt <= fifo_cnt - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= fp_sum;
  end

endmodule
